// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: drives an 8:1 mux, steps sel 0..7, streams sampled bits out.
// Optional macro MUX_SCAN_CHECK_EN builds the sample-vs-d_out mismatch flag.
module mux_scan_ctrl #(
    parameter int unsigned HOLD_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [7:0] load_data,
    output logic [7:0] d_out,
    output logic [2:0] sel,
    input  logic       mux_in,
    output logic       ser_valid,
    input  logic       ser_ready,
    output logic       ser_data,
    output logic       ser_last,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_EMIT
    } state_t;

    localparam logic [3:0] LP_RELOAD = 4'(HOLD_CYC - 1);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_cnt;
    logic [2:0] r_sel;
    logic [7:0] r_dout;
    logic       r_sv;
    logic       r_sd;
    logic       r_sl;
    logic       r_done;
    logic       r_alive;
    logic       w_accept;
    logic       w_hs;
    logic       w_last_ch;
    logic       w_cnt_zero;

    assign w_last_ch  = (r_sel == 3'd7);
    assign w_cnt_zero = (r_cnt == 4'd0);
    // r_alive keeps load_ready low until the first edge after reset release
    assign w_accept   = (r_state == S_IDLE) && r_alive && load_valid;
    assign w_hs       = (r_state == S_EMIT) && ser_ready;

    assign load_ready = (r_state == S_IDLE) && r_alive;
    assign busy       = (r_state != S_IDLE);
    assign d_out      = r_dout;
    assign sel        = r_sel;
    assign ser_valid  = r_sv;
    assign ser_data   = r_sd;
    assign ser_last   = r_sl;
    assign done       = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (w_cnt_zero) w_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                w_next = S_EMIT;
            end
            S_EMIT: begin
                if (w_hs) w_next = w_last_ch ? S_IDLE : S_SETTLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive <= 1'b0;
            r_cnt   <= 4'd0;
            r_sel   <= 3'd0;
            r_dout  <= 8'd0;
            r_sv    <= 1'b0;
            r_sd    <= 1'b0;
            r_sl    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            r_done  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_dout <= load_data;
                        r_sel  <= 3'd0;
                        r_cnt  <= LP_RELOAD;
                    end
                end
                S_SETTLE: begin
                    if (!w_cnt_zero) r_cnt <= r_cnt - 4'd1;
                end
                S_SAMPLE: begin
                    r_sd <= mux_in;
                    r_sv <= 1'b1;
                    r_sl <= w_last_ch;
                end
                S_EMIT: begin
                    if (w_hs) begin
                        r_sv <= 1'b0;
                        if (w_last_ch) begin
                            r_done <= 1'b1;
                        end else begin
                            r_sel <= r_sel + 3'd1;
                            r_cnt <= LP_RELOAD;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MUX_SCAN_CHECK_EN
    logic r_err;
    logic w_mismatch;

    assign w_mismatch = (mux_in != r_dout[r_sel]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if ((r_state == S_SAMPLE) && w_mismatch) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed bench with an ideal 8:1 mux model in the loop.
// Channel 2 can be inverted to exercise the optional mismatch flag.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [7:0] load_data = 8'd0;
    logic [7:0] d_out;
    logic [2:0] sel;
    logic       mux_in;
    logic       ser_valid;
    logic       ser_ready = 1'b0;
    logic       ser_data;
    logic       ser_last;
    logic       busy;
    logic       done;
    logic       err;
    logic       inv_ch2 = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign mux_in = d_out[sel] ^ (inv_ch2 && (sel == 3'd2));

    mux_scan_ctrl #(.HOLD_CYC(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .d_out      (d_out),
        .sel        (sel),
        .mux_in     (mux_in),
        .ser_valid  (ser_valid),
        .ser_ready  (ser_ready),
        .ser_data   (ser_data),
        .ser_last   (ser_last),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Loads w, then collects handshaken bits until done or a cycle budget.
    task automatic run_word(
        input  logic [7:0] w,
        input  int         stall_sel,
        input  int         stall_n,
        input  bit         hammer,
        output logic [7:0] bits,
        output int         nbits,
        output int         t_first,
        output int         t_done,
        output logic [7:0] lastm,
        output logic [7:0] selok,
        output logic [7:0] errm,
        output bit         side_ok
    );
        int   stalls;
        logic sd0;
        logic [2:0] s0;
        bits = 0; nbits = 0; t_first = -1; t_done = -1;
        lastm = 0; selok = 0; errm = 0; side_ok = 1;
        stalls = stall_n; sd0 = 0; s0 = 0;
        check("pre-load ready", load_ready, 1'b1);
        load_data  = w;
        load_valid = 1'b1;
        ser_ready  = 1'b1;
        tick();
        load_valid = hammer;
        load_data  = hammer ? 8'hFF : w;
        for (int n = 0; n < 400; n++) begin
            if (done) begin
                t_done = n;
                break;
            end
            if (!busy || load_ready) side_ok = 0;
            if (ser_valid && t_first < 0) t_first = n;
            ser_ready = 1'b1;
            if (ser_valid && int'(sel) == stall_sel && stalls > 0) begin
                if (stalls == stall_n) begin
                    sd0 = ser_data;
                    s0  = sel;
                end else if (ser_data !== sd0 || sel !== s0) begin
                    side_ok = 0;
                end
                ser_ready = 1'b0;
                stalls--;
            end
            if (ser_valid && ser_ready) begin
                if (nbits < 8) begin
                    bits[nbits]  = ser_data;
                    lastm[nbits] = ser_last;
                    selok[nbits] = (sel == 3'(nbits));
                    errm[nbits]  = err;
                end
                nbits++;
            end
            tick();
        end
        load_valid = 1'b0;
        load_data  = 8'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] bits, lastm, selok, errm;
        int nbits, t_first, t_done;
        bit side_ok;
        bit found;

        #2;
        check("rst d_out", d_out, 8'h00);
        check("rst sel", sel, 3'd0);
        check("rst ser_valid", ser_valid, 1'b0);
        check("rst ser_data", ser_data, 1'b0);
        check("rst ser_last", ser_last, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst err", err, 1'b0);
        check("rst load_ready", load_ready, 1'b0);
        #10;
        rst_n = 1'b1;
        tick();
        check("post-rst load_ready", load_ready, 1'b1);
        check("post-rst busy", busy, 1'b0);

        run_word(8'hA5, -1, 0, 0, bits, nbits, t_first, t_done,
                 lastm, selok, errm, side_ok);
        check("A5 bits", bits, 8'hA5);
        check("A5 nbits", nbits, 8);
        check("A5 first valid", t_first, 2);
        check("A5 done time", t_done, 24);
        check("A5 ser_last", lastm, 8'h80);
        check("A5 sel steps", selok, 8'hFF);
        check("A5 busy/ready", side_ok, 1'b1);
        tick();
        check("A5 done 1-cycle", done, 1'b0);
        check("A5 idle", busy, 1'b0);
        check("A5 d_out held", d_out, 8'hA5);

        run_word(8'h96, 3, 5, 0, bits, nbits, t_first, t_done,
                 lastm, selok, errm, side_ok);
        check("stall bits", bits, 8'h96);
        check("stall nbits", nbits, 8);
        check("stall done time", t_done, 29);
        check("stall sel steps", selok, 8'hFF);
        check("stall stable", side_ok, 1'b1);
        tick();

        run_word(8'h0F, -1, 0, 1, bits, nbits, t_first, t_done,
                 lastm, selok, errm, side_ok);
        check("ignore bits", bits, 8'h0F);
        check("ignore nbits", nbits, 8);
        check("ignore done time", t_done, 24);
        tick();
        check("ignore no accept", busy, 1'b0);
        check("ignore d_out", d_out, 8'h0F);

        load_data  = 8'hC3;
        load_valid = 1'b1;
        ser_ready  = 1'b1;
        tick();
        load_valid = 1'b0;
        found = 0;
        for (int n = 0; n < 100; n++) begin
            if (sel == 3'd4) begin
                found = 1;
                break;
            end
            tick();
        end
        check("reach sel 4", found, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst sel", sel, 3'd0);
        check("midrst d_out", d_out, 8'h00);
        check("midrst ser_valid", ser_valid, 1'b0);
        check("midrst busy", busy, 1'b0);
        check("midrst done", done, 1'b0);
        #3;
        rst_n = 1'b1;
        tick();
        check("midrst no done", done, 1'b0);
        check("midrst ready", load_ready, 1'b1);

        run_word(8'h3C, -1, 0, 0, bits, nbits, t_first, t_done,
                 lastm, selok, errm, side_ok);
        check("3C bits", bits, 8'h3C);
        check("3C first valid", t_first, 2);
        check("3C done time", t_done, 24);
        check("3C sel steps", selok, 8'hFF);
        tick();

        inv_ch2 = 1'b1;
        run_word(8'hA5, -1, 0, 0, bits, nbits, t_first, t_done,
                 lastm, selok, errm, side_ok);
        inv_ch2 = 1'b0;
        check("inv bits", bits, 8'hA1);
        tick();
`ifdef MUX_SCAN_CHECK_EN
        check("inv err per bit", errm, 8'hFC);
        check("inv err sticky", err, 1'b1);
`else
        check("inv err per bit", errm, 8'h00);
        check("inv err tied", err, 1'b0);
`endif
        run_word(8'h5A, -1, 0, 0, bits, nbits, t_first, t_done,
                 lastm, selok, errm, side_ok);
        check("clean bits", bits, 8'h5A);
        check("err cleared", errm, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
